// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM states, parity encodings and baud divisor table for the UART receiver
// Contents: rx_state_e, PAR_* parity_mode codes, baud_rate()/baud_div() table indexed by baud_select.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    // parity_mode 2'b11 also means no parity
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int DIV_W = 16;

    function automatic int unsigned baud_rate(input logic [2:0] sel);
        int unsigned rate;
        case (sel)
            3'd0:    rate = 1200;
            3'd1:    rate = 2400;
            3'd2:    rate = 4800;
            3'd3:    rate = 9600;
            3'd4:    rate = 19200;
            3'd5:    rate = 38400;
            3'd6:    rate = 57600;
            default: rate = 115200;
        endcase
        return rate;
    endfunction

    // clk cycles per 16x oversampling tick; never below 1
    function automatic logic [DIV_W-1:0] baud_div(input int unsigned clk_hz, input logic [2:0] sel);
        int unsigned d;
        d = clk_hz / (16 * baud_rate(sel));
        if (d == 0) begin
            d = 1;
        end
        return DIV_W'(d);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - 16x oversampling tick generator with per-code divisor table
// Ports: clk, rst (sync, active-high), baud_select[2:0] (rate code), tick (1-cycle pulse at 16x baud).
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50000000
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] baud_select,
    output logic       tick
);

    // divisors are elaboration-time constants, so no runtime divider is built
    localparam logic [DIV_W-1:0] DIV0 = baud_div(CLK_HZ, 3'd0);
    localparam logic [DIV_W-1:0] DIV1 = baud_div(CLK_HZ, 3'd1);
    localparam logic [DIV_W-1:0] DIV2 = baud_div(CLK_HZ, 3'd2);
    localparam logic [DIV_W-1:0] DIV3 = baud_div(CLK_HZ, 3'd3);
    localparam logic [DIV_W-1:0] DIV4 = baud_div(CLK_HZ, 3'd4);
    localparam logic [DIV_W-1:0] DIV5 = baud_div(CLK_HZ, 3'd5);
    localparam logic [DIV_W-1:0] DIV6 = baud_div(CLK_HZ, 3'd6);
    localparam logic [DIV_W-1:0] DIV7 = baud_div(CLK_HZ, 3'd7);
    localparam logic [DIV_W-1:0] ONE  = 1;

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] cnt;
    logic [2:0]       sel_q;

    always_comb begin
        div = DIV7;
        case (sel_q)
            3'd0:    div = DIV0;
            3'd1:    div = DIV1;
            3'd2:    div = DIV2;
            3'd3:    div = DIV3;
            3'd4:    div = DIV4;
            3'd5:    div = DIV5;
            3'd6:    div = DIV6;
            default: div = DIV7;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            sel_q <= 3'd0;
            tick  <= 1'b0;
        end else if (baud_select != sel_q) begin
            // restart the period so the new rate starts from a clean phase
            sel_q <= baud_select;
            cnt   <= '0;
            tick  <= 1'b0;
        end else if (cnt >= div - ONE) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + ONE;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parameterised UART receiver with parity/framing/overrun flags and ready/valid output
// Ports: clk, rst (sync, active-high), baud_select[2:0], rx_en, rxd (async, idle high), parity_mode[1:0],
//        stop_bits, rx_data[DATA_W-1:0], rx_valid, rx_ready, rx_perror, rx_ferror, rx_overrun (sticky).
// Build option: define UART_RX_MAJORITY_EN for 2-of-3 majority over ticks 6/7/8 (decision at tick 8).
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int          DATA_W = 8,
    parameter int unsigned CLK_HZ = 50000000
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        baud_select,
    input  logic              rx_en,
    input  logic              rxd,
    input  logic [1:0]        parity_mode,
    input  logic              stop_bits,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_perror,
    output logic              rx_ferror,
    output logic              rx_overrun
);

`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0] DECIDE_TICK = 4'd8;
`else
    localparam logic [3:0] DECIDE_TICK = 4'd7;
`endif
    localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

    logic              rxd_meta, rxd_sync, rxd_prev;
    rx_state_e         state, state_n;
    logic [3:0]        tick_cnt, tick_cnt_n;
    logic [3:0]        bit_cnt, bit_cnt_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic [1:0]        par_q, par_n;
    logic              stop2_q, stop2_n;
    logic [2:0]        baud_q, baud_n;
    logic              perr_q, perr_n;
    logic              ferr_q, ferr_n;
    logic              done_n;
    logic              tick, decide, wrap, fall, bit_val, par_en;
    logic [2:0]        gen_sel;

    // the frame runs at the rate latched at START; IDLE follows the live code
    assign gen_sel = (state == ST_IDLE) ? baud_select : baud_q;

    uart_baud_gen #(.CLK_HZ(CLK_HZ)) u_baud_gen (
        .clk         (clk),
        .rst         (rst),
        .baud_select (gen_sel),
        .tick        (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    assign fall   = rxd_prev & ~rxd_sync;
    assign decide = tick && (tick_cnt == DECIDE_TICK);
    assign wrap   = tick && (tick_cnt == 4'd15);
    assign par_en = (par_q == PAR_EVEN) || (par_q == PAR_ODD);

`ifdef UART_RX_MAJORITY_EN
    logic s6_q, s7_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s6_q <= 1'b1;
            s7_q <= 1'b1;
        end else if (tick) begin
            if (tick_cnt == 4'd6) s6_q <= rxd_sync;
            if (tick_cnt == 4'd7) s7_q <= rxd_sync;
        end
    end

    // tick-8 sample is the live synchronized value in the decision cycle
    assign bit_val = (s6_q & s7_q) | (s6_q & rxd_sync) | (s7_q & rxd_sync);
`else
    assign bit_val = rxd_sync;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            tick_cnt <= 4'd0;
            bit_cnt  <= 4'd0;
            shreg    <= '0;
            par_q    <= PAR_NONE;
            stop2_q  <= 1'b0;
            baud_q   <= 3'd0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state    <= state_n;
            tick_cnt <= tick_cnt_n;
            bit_cnt  <= bit_cnt_n;
            shreg    <= shreg_n;
            par_q    <= par_n;
            stop2_q  <= stop2_n;
            baud_q   <= baud_n;
            perr_q   <= perr_n;
            ferr_q   <= ferr_n;
        end
    end

    always_comb begin
        state_n    = state;
        tick_cnt_n = tick_cnt;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        par_n      = par_q;
        stop2_n    = stop2_q;
        baud_n     = baud_q;
        perr_n     = perr_q;
        ferr_n     = ferr_q;
        done_n     = 1'b0;

        // 4-bit counter wraps 15 -> 0 on its own, marking the bit boundary
        if (state != ST_IDLE && tick) begin
            tick_cnt_n = tick_cnt + 4'd1;
        end

        case (state)
            ST_IDLE: begin
                tick_cnt_n = 4'd0;
                bit_cnt_n  = 4'd0;
                if (rx_en && fall) begin
                    state_n = ST_START;
                    par_n   = parity_mode;
                    stop2_n = stop_bits;
                    baud_n  = baud_select;
                    perr_n  = 1'b0;
                    ferr_n  = 1'b0;
                end
            end
            ST_START: begin
                if (decide && bit_val) begin
                    state_n = ST_IDLE;
                end else if (wrap) begin
                    state_n   = ST_DATA;
                    bit_cnt_n = 4'd0;
                end
            end
            ST_DATA: begin
                if (decide) begin
                    shreg_n = {bit_val, shreg[DATA_W-1:1]};
                end
                if (wrap) begin
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_n = 4'd0;
                        state_n   = par_en ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (decide) begin
                    perr_n = bit_val ^ (^shreg) ^ (par_q == PAR_ODD);
                end
                if (wrap) begin
                    state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                if (decide) begin
                    ferr_n = ferr_q | ~bit_val;
                    // leave mid-bit so a start edge right after the stop bit is caught
                    if (!stop2_q || bit_cnt == 4'd1) begin
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                    end
                end
                if (wrap) begin
                    bit_cnt_n = 4'd1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (state != ST_IDLE && !rx_en) begin
            state_n = ST_IDLE;
            done_n  = 1'b0;
        end
    end

    // output holding register: loads on the cycle after the final stop sample
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_perror  <= 1'b0;
            rx_ferror  <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            if (rx_valid && rx_ready) begin
                rx_valid   <= 1'b0;
                rx_overrun <= 1'b0;
            end
            if (done_n) begin
                if (!rx_valid || rx_ready) begin
                    rx_data   <= shreg;
                    rx_perror <= perr_q;
                    rx_ferror <= ferr_n;
                    rx_valid  <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter DATA_W, default 8, data bits per frame, legal range 5..9.
REQ-002 Parameter CLK_HZ, default 50000000, clk frequency passed to the baud generator.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 baud_select  input  3  baud rate code (000=1200 ... 111=115200), read continuously.
REQ-006 rx_en  input  1  receiver enable.
REQ-007 rxd  input  1  asynchronous serial line, idle high.
REQ-008 parity_mode  input  2  00 none, 01 even, 10 odd, 11 none.
REQ-009 stop_bits  input  1  0 = one stop bit, 1 = two stop bits.
REQ-010 rx_data  output  DATA_W  received word, LSB at bit 0.
REQ-011 rx_valid  output  1  rx_data and its error flags are valid.
REQ-012 rx_ready  input  1  consumer accepts the word on rx_valid && rx_ready.
REQ-013 rx_perror, rx_ferror  output  1 each  parity and framing error for the held word.
REQ-014 rx_overrun  output  1  sticky flag: a completed frame was dropped; cleared by the next handshake.

Function
REQ-015 rxd shall pass through a 2-flop synchronizer, and only the synchronized value shall be used.
REQ-016 The FSM shall have the states IDLE, START, DATA, PARITY, STOP, implemented as a 4-bit tick counter (0..15 per bit) plus a bit counter.
REQ-017 IDLE->START shall occur on a synchronized 1->0 transition while rx_en=1, and the tick counter shall clear to 0.
REQ-018 The sample point shall be tick 7; at the START sample, a high line shall be a false start -> IDLE with no output.
REQ-019 Bits shall advance when the tick counter wraps from 15 to 0, and data shall be shifted LSB-first, DATA_W bits.
REQ-020 PARITY shall be entered only if parity_mode is 01 or 10, and rx_perror shall be set when the sampled bit differs from the even/odd parity of the data.
REQ-021 STOP shall sample 1 or 2 stop bits per stop_bits, and rx_ferror shall be set if any sampled stop bit is 0.
REQ-022 After the last stop sample the FSM shall return to IDLE immediately, without waiting for the bit end, so back-to-back frames are accepted.
REQ-023 Word, rx_perror and rx_ferror shall be loaded into the output register, and rx_valid shall rise, exactly 1 clk after the final stop sample tick.
REQ-024 rx_valid shall remain high with all outputs stable until a cycle with rx_ready=1, then clear in the next cycle unless a new word loads in that same cycle.
REQ-025 If a frame completes while rx_valid=1 and rx_ready=0, the new frame shall be discarded, rx_overrun shall be set, and the held word shall be unchanged.
REQ-026 If a frame completes in the same cycle as a handshake, the new word shall load, rx_valid shall stay 1, and no overrun shall be flagged.
REQ-027 If rx_en falls mid-frame, the FSM shall go to IDLE on the next clk and the partial frame shall be discarded; the output register shall be unaffected.
REQ-028 parity_mode, stop_bits and baud_select shall be sampled at START entry and held for the frame.

Reset
REQ-029 rst shall set the FSM to IDLE, counters to 0, synchronizer flops to 1, rx_data to 0, and rx_valid/rx_perror/rx_ferror/rx_overrun to 0, and shall take priority over all other events, including mid-frame.

Configuration
REQ-030 With UART_RX_MAJORITY_EN defined, each bit value shall be the 2-of-3 majority of ticks 6, 7 and 8, and the decision shall be taken at tick 8.
REQ-031 With UART_RX_MAJORITY_EN undefined, each bit value shall be the single tick-7 sample, and all latencies shall be defined relative to tick 7.

Structure
REQ-032 The shared package uart_pkg shall hold the FSM state enum, the parity_mode encodings, and the baud divisor table indexed by baud_select.
REQ-033 The sub-module uart_baud_gen(clk, rst, baud_select, tick) shall produce a 1-cycle tick at 16x the baud rate, and its divisor shall reload on a baud_select change.

Verification
REQ-034 The bench shall cover: 8N1, baud 111, byte 0xA5, rx_ready=1 -> rx_data=0xA5, rx_valid pulse of 1 clk, no error flags.
REQ-035 The bench shall cover: even parity, byte 0x03, parity bit 1 -> rx_data=0x03, rx_perror=1, rx_ferror=0.
REQ-036 The bench shall cover: 8N2, byte 0x5A, second stop bit 0 -> rx_ferror=1, rx_data=0x5A.
REQ-037 The bench shall cover: two frames 0x11 then 0x22 with rx_ready=0 -> rx_data=0x11 held, rx_overrun=1; after a handshake, rx_overrun=0.
REQ-038 The bench shall cover: a low pulse of 4 tick-lengths on an idle line -> no rx_valid, FSM back to IDLE.
REQ-039 The bench shall cover: rst asserted mid-DATA of 0xFF -> all outputs 0 next clk; a following frame 0x3C is received correctly.
